// File: rtl/pwm_duty_ramp.sv
// Soft-start duty ramp: accepts a target duty over valid/ready and slews the registered
// duty_cycle toward it by at most STEP every PRESCALE clocks, with a synchronous kill.
module pwm_duty_ramp #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 16,
  parameter int unsigned STEP     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_duty,
  output logic             tgt_ready,
  input  logic             kill,
  output logic [WIDTH-1:0] duty_cycle,
  output logic             busy,
  output logic             done
);

  localparam logic [15:0]      PcntLast = 16'(PRESCALE - 1);
  localparam logic [WIDTH:0]   StepW    = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] StepN    = WIDTH'(STEP);

  typedef enum logic [1:0] {
    StIdle,
    StRampUp,
    StRampDown
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [15:0]      pcnt_q, pcnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Differences carry an extra bit so the final partial step can never wrap.
  logic [WIDTH:0] diff_up;
  logic [WIDTH:0] diff_dn;
  logic           step_now;

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    pcnt_d   = pcnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_up  = {1'b0, target_q} - {1'b0, duty_q};
    diff_dn  = {1'b0, duty_q} - {1'b0, target_q};
    step_now = (pcnt_q == PcntLast);

    if (kill) begin
      state_d  = StIdle;
      duty_d   = '0;
      target_d = '0;
      pcnt_d   = '0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          pcnt_d = '0;
          if (tgt_valid) begin
            target_d = tgt_duty;
            if (tgt_duty > duty_q) begin
              state_d = StRampUp;
              busy_d  = 1'b1;
            end else if (tgt_duty < duty_q) begin
              state_d = StRampDown;
              busy_d  = 1'b1;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        StRampUp: begin
          if (step_now) begin
            pcnt_d = '0;
            if (diff_up <= StepW) begin
              duty_d  = target_q;
              state_d = StIdle;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              duty_d = duty_q + StepN;
            end
          end else begin
            pcnt_d = pcnt_q + 16'd1;
          end
        end
        default: begin
          if (step_now) begin
            pcnt_d = '0;
            if (diff_dn <= StepW) begin
              duty_d  = target_q;
              state_d = StIdle;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              duty_d = duty_q - StepN;
            end
          end else begin
            pcnt_d = pcnt_q + 16'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      duty_q   <= '0;
      target_q <= '0;
      pcnt_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      pcnt_q   <= pcnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tgt_ready  = (state_q == StIdle) && !kill;
  assign duty_cycle = duty_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Scoreboard bench for pwm_duty_ramp: stimulus pushes expected duty/done events computed from
// the ramp rules; a negedge monitor pops them whenever duty_cycle changes or done pulses.
module tb_pwm_duty_ramp;
  localparam int W = 8;
  localparam int P = 4;
  localparam int S = 16;

  logic         clk       = 1'b0;
  logic         reset     = 1'b1;
  logic         tgt_valid = 1'b1;
  logic [W-1:0] tgt_duty  = 8'd100;
  logic         kill      = 1'b0;
  logic         tgt_ready;
  logic [W-1:0] duty_cycle;
  logic         busy;
  logic         done;

  pwm_duty_ramp #(
    .WIDTH   (W),
    .PRESCALE(P),
    .STEP    (S)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tgt_valid (tgt_valid),
    .tgt_duty  (tgt_duty),
    .tgt_ready (tgt_ready),
    .kill      (kill),
    .duty_cycle(duty_cycle),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int duty;
    bit done;
  } ev_t;
  ev_t exp_q[$];

  int model_duty = 0;
  int acc_edge   = 0;
  int done_edge  = 0;
  bit mon_en     = 1'b0;
  bit finish_req = 1'b0;
  int checks     = 0;
  int errors     = 0;

  task automatic wait_edge();
    @(posedge clk);
    #2;
  endtask

  // Issue one target once the model says the block is idle; queue every expected step event.
  task automatic send(input int t);
    int d, mag, steps, v;
    ev_t e;
    while (cyc < done_edge) wait_edge();
    tgt_valid = 1'b1;
    tgt_duty  = W'(t);
    wait_edge();
    tgt_valid = 1'b0;
    acc_edge  = cyc;
    d         = t - model_duty;
    mag       = (d < 0) ? -d : d;
    steps     = (mag + S - 1) / S;
    if (steps == 0) begin
      e = '{cyc: cyc, duty: t, done: 1'b1};
      exp_q.push_back(e);
    end
    for (int k = 1; k <= steps; k++) begin
      if (d > 0) v = (model_duty + k * S > t) ? t : model_duty + k * S;
      else       v = (model_duty - k * S < t) ? t : model_duty - k * S;
      e = '{cyc: cyc + k * P, duty: v, done: (k == steps)};
      exp_q.push_back(e);
    end
    done_edge  = cyc + steps * P;
    model_duty = t;
  endtask

  // Ramp 0->128 and abort it with kill or reset sampled at acceptance edge + 9.
  task automatic abort_ramp(input bit use_kill);
    int  n;
    ev_t e;
    send(0);
    send(128);
    n = acc_edge;
    while (cyc < n + 8) wait_edge();
    while (exp_q.size() > 0 && exp_q[$].cyc > n + 8) void'(exp_q.pop_back());
    e = '{cyc: n + 9, duty: 0, done: 1'b0};
    exp_q.push_back(e);
    done_edge  = n + 9;
    model_duty = 0;
    if (use_kill) kill = 1'b1;
    else          reset = 1'b1;
    wait_edge();
    if (use_kill) repeat (2) wait_edge();
    kill  = 1'b0;
    reset = 1'b0;
    wait_edge();
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #2;
    reset     = 1'b0;
    tgt_valid = 1'b0;
    mon_en    = 1'b1;
    repeat (3) wait_edge();

    send(64);
    send(10);
    send(0);
    send(255);
    send(64);
    send(64);
    send(128);
    n = acc_edge;
    while (cyc < n + 5) wait_edge();
    tgt_valid = 1'b1;
    tgt_duty  = '0;
    wait_edge();
    tgt_valid = 1'b0;

    abort_ramp(1'b1);
    abort_ramp(1'b0);

    repeat (24) begin
      repeat ($urandom_range(0, 3)) wait_edge();
      send(int'($urandom_range(0, 255)));
    end

    while (cyc < done_edge) wait_edge();
    repeat (3) wait_edge();
    finish_req = 1'b1;
  end

  initial begin
    int  prev = 0;
    bit  exp_busy, exp_ready;
    ev_t e;
    forever begin
      @(negedge clk);
      if (finish_req) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL drain: %0d events still pending, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
      if (mon_en) begin
        exp_busy  = (cyc >= acc_edge) && (cyc < done_edge);
        exp_ready = !exp_busy && !kill;
        checks++;
        if (busy !== exp_busy) begin
          errors++;
          $display("FAIL busy @%0d: got %b, required %b", cyc, busy, exp_busy);
        end
        checks++;
        if (tgt_ready !== exp_ready) begin
          errors++;
          $display("FAIL tgt_ready @%0d: got %b, required %b", cyc, tgt_ready, exp_ready);
        end
        if (duty_cycle !== W'(prev) || done !== 1'b0) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected event @%0d: duty %0d done %b, required no change",
                     cyc, duty_cycle, done);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || duty_cycle !== W'(e.duty) || done !== e.done) begin
              errors++;
              $display("FAIL event: got edge %0d duty %0d done %b, required edge %0d duty %0d done %b",
                       cyc, duty_cycle, done, e.cyc, e.duty, e.done);
            end
          end
        end
        prev = int'(duty_cycle);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pwm_duty_ramp.md
# pwm_duty_ramp

Upstream soft-start stage for `pwm_generator`. It accepts a target duty value through a valid/ready handshake. It then slews its registered `duty_cycle` output toward that target in fixed steps at a fixed step interval, so the PWM never sees abrupt duty jumps. `duty_cycle` connects directly to the `duty_cycle` input of `pwm_generator`, and both blocks share the same `clk` and `reset`.

## Interface
- `WIDTH`, default 8: duty width. Must match `pwm_generator`.
- `PRESCALE`, default 16: clock cycles per ramp step. Legal range is 1 to 65535.
- `STEP`, default 1: maximum duty change per step. Legal range is 1 to 2^WIDTH-1.
- `clk`, input, 1: the single clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `tgt_valid`, input, 1: a new target is presented.
- `tgt_duty`, input, WIDTH: the target duty value.
- `tgt_ready`, output, 1: the block can accept a target. Combinational: `(state==IDLE) && !kill`.
- `kill`, input, 1: emergency off. Level-sensitive and synchronous.
- `duty_cycle`, output, WIDTH: the registered duty value fed to the PWM.
- `busy`, output, 1: registered. High while in RAMP_UP or RAMP_DOWN.
- `done`, output, 1: registered one-cycle pulse when `duty_cycle` reaches the target.

## Operation
- **States:** IDLE, RAMP_UP, RAMP_DOWN. Internal registers are `target[WIDTH-1:0]` and prescale counter `pcnt[15:0]`.
- **Priority per edge:** `reset`, then `kill`, then normal operation.
- **Reset:** sets `state=IDLE`, `duty_cycle=0`, `target=0`, `pcnt=0`, `busy=0`, `done=0`. `tgt_valid` is ignored in a reset cycle.
- **Kill:** while `kill=1`, each edge forces `state=IDLE`, `duty_cycle=0`, `target=0`, `pcnt=0`, `busy=0` and `done=0`. No done pulse is produced for an aborted ramp.
- **Accept:** a target is accepted on an edge where `tgt_valid && tgt_ready`. On that edge:
  - `target<=tgt_duty` and `pcnt<=0`.
  - If `tgt_duty>duty_cycle`, go to RAMP_UP and set `busy<=1`.
  - If `tgt_duty<duty_cycle`, go to RAMP_DOWN and set `busy<=1`.
  - If `tgt_duty==duty_cycle`, stay in IDLE and set `done<=1`.
- **Ramp states:** `tgt_ready=0`, so `tgt_valid` is ignored and the target cannot change mid-ramp.
- **Prescale counter:** in a ramp state, `pcnt` increments each edge. When `pcnt==PRESCALE-1`, it wraps to 0 and a step occurs on that edge.
- **Step, RAMP_UP:** `duty_cycle <= (target-duty_cycle <= STEP) ? target : duty_cycle+STEP`.
- **Step, RAMP_DOWN:** `duty_cycle <= (duty_cycle-target <= STEP) ? target : duty_cycle-STEP`.
- **Arithmetic rules:** differences are computed in WIDTH+1 bits. The output never overshoots the target and never wraps past 0 or 2^WIDTH-1.
- **Step completion:** when a step lands on the target, the same edge sets `state<=IDLE`, `busy<=0` and `done<=1`.
- **Done pulse:** `done` is high for exactly one cycle. A new acceptance is possible in the cycle where `done` is high.
- **IDLE:** `duty_cycle` holds its value and `pcnt` stays at 0.

## Timing
- **Step edges:** for a target accepted at edge N, step k occurs at edge N + k·PRESCALE.
- **Step count:** steps = ceil(|target − duty_cycle at acceptance| / STEP).
- **Latency:** from the acceptance edge to the edge that raises `done` is steps·PRESCALE cycles. For an equal target, `done` rises on the acceptance edge (latency 0) and `busy` stays 0.
- **Outputs:** `duty_cycle`, `busy` and `done` are registered. `tgt_ready` is combinational from state and `kill`.
- **PRESCALE=1:** one step per clock. Back-to-back ramps are legal.
- **Kill:** `kill` asserted at edge M gives `duty_cycle=0` after edge M. `tgt_ready` returns the cycle `kill` drops.
- **Reset mid-ramp:** identical to kill, with all registers at their reset values after the edge.

## Test plan
Bench overrides are `PRESCALE=4` and `STEP=16`. N is the acceptance edge.
1. **Reset:** hold `reset` for 2 cycles with `tgt_valid=1` and `tgt_duty=100`. Required: `duty_cycle=0`, `busy=0`, `done=0` and `tgt_ready=1` after release, with no ramp started.
2. **Ramp up 0→64:** `duty_cycle` = 16, 32, 48, 64 after edges N+4, N+8, N+12, N+16. `busy=1` from N to N+16. `done` pulses for one cycle after N+16. `tgt_ready=0` throughout the ramp.
3. **Ramp down 64→10:** `duty_cycle` = 48, 32, 16, 10 after edges N+4 to N+16, with a partial final step and no underflow. `done` at N+16.
4. **Saturation 0→255:** 16 steps, with the final step going 240→255 at N+64. The output never wraps to 0, and `done` is a single pulse.
5. **Equal target and mid-ramp request:** request 64 while `duty_cycle=64`; required: `done` after N, `busy` never set. Then start 64→128 and present `tgt_valid` with 0 at N+6; required: request ignored and `duty_cycle` reaches 128 at N+16.
6. **Kill and reset mid-ramp:** during 0→128, raise `kill` at N+9; required: `duty_cycle=0`, `busy=0` and no `done` after that edge, `tgt_ready=0` while `kill=1`. Repeat with `reset` instead of `kill` for the same result.
